// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that merges byte packets from NUM_REQ requesters onto a
// single UART transmit byte stream, with an idle watchdog on the granted port.
module uart_tx_arb #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_pulse
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic {ST_ARB, ST_XFER} state_t;

  state_t        r_state, w_state_nxt;
  logic [GW-1:0] r_grant_id, w_grant_nxt;
  logic [GW-1:0] r_last_grant, w_last_nxt;
  logic [CW-1:0] r_idle, w_idle_nxt;
  logic          r_tx_valid, w_tx_valid_nxt;
  logic [7:0]    r_tx_data, w_tx_data_nxt;
  logic          r_timeout, w_timeout_nxt;

  logic          w_pick_found;
  logic [GW-1:0] w_pick;
  logic          w_g_valid;
  logic          w_g_last;
  logic [7:0]    w_g_data;
  logic          w_can_load;
  logic          w_beat;
  logic [NUM_REQ-1:0] w_req_ready;

  // Search upward starting one past the last grant so every port gets a turn.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_pick_found && req_valid[(32'(r_last_grant) + k) % NUM_REQ]) begin
        w_pick_found = 1'b1;
        w_pick       = GW'((32'(r_last_grant) + k) % NUM_REQ);
      end
    end
  end

  assign w_g_valid  = req_valid[r_grant_id];
  assign w_g_last   = req_last[r_grant_id];
  assign w_g_data   = req_data[{r_grant_id, 3'b000} +: 8];
  assign w_can_load = !r_tx_valid || tx_ready;
  assign w_beat     = (r_state == ST_XFER) && w_g_valid && w_can_load;

  always_comb begin
    w_req_ready = '0;
    if ((r_state == ST_XFER) && w_can_load)
      w_req_ready[r_grant_id] = 1'b1;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant_id;
    w_last_nxt     = r_last_grant;
    w_idle_nxt     = r_idle;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    w_timeout_nxt  = 1'b0;

    // Output register runs in both states so a held byte drains after revocation.
    if (w_beat) begin
      w_tx_valid_nxt = 1'b1;
      w_tx_data_nxt  = w_g_data;
    end else if (r_tx_valid && tx_ready) begin
      w_tx_valid_nxt = 1'b0;
    end

    if (r_state == ST_ARB) begin
      if (w_pick_found) begin
        w_grant_nxt = w_pick;
        w_idle_nxt  = '0;
        w_state_nxt = ST_XFER;
      end
    end else begin
      if (w_beat) begin
        w_idle_nxt = '0;
        if (w_g_last) begin
          w_state_nxt = ST_ARB;
          w_last_nxt  = r_grant_id;
        end
      end else if (!w_g_valid) begin
        if (r_idle >= CW'(TIMEOUT_CYC - 1)) begin
          w_state_nxt   = ST_ARB;
          w_last_nxt    = r_grant_id;
          w_timeout_nxt = 1'b1;
        end else if (r_idle != '1) begin
          w_idle_nxt = r_idle + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= ST_ARB;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_idle       <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_idle       <= w_idle_nxt;
      r_tx_valid   <= w_tx_valid_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign req_ready     = w_req_ready;
  assign tx_valid      = r_tx_valid;
  assign tx_data       = r_tx_data;
  assign grant_id      = r_grant_id;
  assign busy          = (r_state == ST_XFER) || r_tx_valid;
  assign timeout_pulse = r_timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: 4 requesters, 16-cycle idle timeout.
module tb_uart_tx_arb;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_pulse;

  int n_chk = 0;
  int n_err = 0;

  uart_tx_arb #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nedge(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic setd(input int i, input logic [7:0] d);
    req_data[8*i +: 8] = d;
  endtask

  initial begin
    int bad_data, bad_ready, bad_tp, bad_grant;

    aresetn   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    nedge(2);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tp", timeout_pulse, 0);

    // Single requester: req1 sends 41, 42(last)
    req_valid = 4'b0010; setd(1, 8'h41); req_last = 4'b0000;
    aresetn = 1'b1;
    nedge(1);
    chk("t1_grant", grant_id, 1);
    chk("t1_busy", busy, 1);
    chk("t1_ready0", req_ready, 4'b0010);
    chk("t1_txv0", tx_valid, 0);
    nedge(1);
    chk("t1_txv1", tx_valid, 1);
    chk("t1_data41", tx_data, 8'h41);
    chk("t1_ready_held", req_ready, 0);
    setd(1, 8'h42); req_last = 4'b0010; tx_ready = 1'b1;
    #1;
    chk("t1_ready_pop", req_ready, 4'b0010);
    nedge(1);
    chk("t1_data42", tx_data, 8'h42);
    chk("t1_txv2", tx_valid, 1);
    tx_ready = 1'b0; req_valid = '0; req_last = '0;
    nedge(1);
    chk("t1_busy_held", busy, 1);
    chk("t1_data_stable", tx_data, 8'h42);
    chk("t1_ready_arb", req_ready, 0);
    tx_ready = 1'b1;
    nedge(1);
    chk("t1_txv_clr", tx_valid, 0);
    chk("t1_idle", busy, 0);
    chk("t1_grant_kept", grant_id, 1);
    tx_ready = 1'b0;

    // Contention: all four with 1-byte packets -> 0,1,2,3,0
    aresetn = 1'b0;
    nedge(2);
    req_valid = 4'b1111; req_last = 4'b1111;
    setd(0, 8'h10); setd(1, 8'h11); setd(2, 8'h12); setd(3, 8'h13);
    tx_ready = 1'b1;
    aresetn = 1'b1;
    for (int it = 0; it < 5; it++) begin
      nedge(1);
      chk("t2_grant", grant_id, it % 4);
      chk("t2_ready", req_ready, 32'd1 << (it % 4));
      nedge(1);
      chk("t2_data", tx_data, 8'h10 + (it % 4));
      chk("t2_txv", tx_valid, 1);
    end
    req_valid = '0; req_last = '0;
    nedge(1);
    chk("t2_drain", tx_valid, 0);
    chk("t2_idle", busy, 0);

    // Non-interleave: req0 AA,BB,CC while req2 waits with 55
    aresetn = 1'b0;
    nedge(2);
    req_valid = 4'b0101; req_last = 4'b0100;
    setd(0, 8'hAA); setd(2, 8'h55);
    tx_ready = 1'b1;
    aresetn = 1'b1;
    nedge(1);
    chk("t3_grant0", grant_id, 0);
    chk("t3_ready0", req_ready, 4'b0001);
    nedge(1);
    chk("t3_dataAA", tx_data, 8'hAA);
    chk("t3_ready_aa", req_ready, 4'b0001);
    setd(0, 8'hBB);
    nedge(1);
    chk("t3_dataBB", tx_data, 8'hBB);
    chk("t3_txvBB", tx_valid, 1);
    chk("t3_grant_hold", grant_id, 0);
    setd(0, 8'hCC); req_last = 4'b0101;
    nedge(1);
    chk("t3_dataCC", tx_data, 8'hCC);
    req_valid = 4'b0100;
    nedge(1);
    chk("t3_grant2", grant_id, 2);
    chk("t3_txv_gap", tx_valid, 0);
    nedge(1);
    chk("t3_data55", tx_data, 8'h55);
    chk("t3_txv55", tx_valid, 1);
    req_valid = '0; req_last = '0;
    nedge(1);
    chk("t3_idle", busy, 0);

    // Backpressure: tx_ready low for 500 cycles
    req_valid = 4'b0010; setd(1, 8'h77); req_last = '0; tx_ready = 1'b0;
    nedge(1);
    chk("t4_grant1", grant_id, 1);
    nedge(1);
    chk("t4_data77", tx_data, 8'h77);
    chk("t4_txv", tx_valid, 1);
    setd(1, 8'h88);
    bad_data = 0; bad_ready = 0; bad_tp = 0; bad_grant = 0;
    for (int c = 0; c < 500; c++) begin
      nedge(1);
      if (tx_data !== 8'h77 || tx_valid !== 1'b1) bad_data++;
      if (req_ready !== 4'b0000) bad_ready++;
      if (timeout_pulse !== 1'b0) bad_tp++;
      if (grant_id !== 2'd1) bad_grant++;
    end
    chk("t4_bad_data_cycles", bad_data, 0);
    chk("t4_bad_ready_cycles", bad_ready, 0);
    chk("t4_bad_tp_cycles", bad_tp, 0);
    chk("t4_bad_grant_cycles", bad_grant, 0);
    tx_ready = 1'b1; req_last = 4'b0010;
    #1;
    chk("t4_ready_release", req_ready, 4'b0010);
    nedge(1);
    chk("t4_data88", tx_data, 8'h88);
    chk("t4_txv88", tx_valid, 1);
    req_valid = '0; req_last = '0;
    nedge(1);
    chk("t4_idle", busy, 0);

    // Timeout: req3 sends one byte then stalls; req1 granted after revocation
    req_valid = 4'b1000; setd(3, 8'h33); req_last = '0; tx_ready = 1'b1;
    nedge(1);
    chk("t5_grant3", grant_id, 3);
    nedge(1);
    chk("t5_data33", tx_data, 8'h33);
    req_valid = 4'b0010; setd(1, 8'h99); req_last = 4'b0010;
    bad_tp = 0; bad_grant = 0;
    for (int k = 3; k <= 17; k++) begin
      nedge(1);
      if (timeout_pulse !== 1'b0) bad_tp++;
      if (grant_id !== 2'd3) bad_grant++;
    end
    chk("t5_early_tp_cycles", bad_tp, 0);
    chk("t5_grant_kept_cycles", bad_grant, 0);
    chk("t5_ready_stalled", req_ready, 4'b1000);
    nedge(1);
    chk("t5_tp", timeout_pulse, 1);
    chk("t5_grant_at_tp", grant_id, 3);
    chk("t5_ready_at_tp", req_ready, 0);
    nedge(1);
    chk("t5_tp_one_cycle", timeout_pulse, 0);
    chk("t5_grant_next", grant_id, 1);
    chk("t5_ready_next", req_ready, 4'b0010);
    nedge(1);
    chk("t5_data99", tx_data, 8'h99);
    req_valid = '0; req_last = '0;
    nedge(1);

    // Reset mid-packet with a held byte
    req_valid = 4'b0100; setd(2, 8'hEE); req_last = '0; tx_ready = 1'b0;
    nedge(1);
    chk("t6_grant2", grant_id, 2);
    nedge(1);
    chk("t6_txv", tx_valid, 1);
    chk("t6_dataEE", tx_data, 8'hEE);
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_async_txv", tx_valid, 0);
    chk("t6_async_data", tx_data, 0);
    chk("t6_async_grant", grant_id, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_ready", req_ready, 0);
    req_valid = 4'b0101; setd(0, 8'hC0); req_last = 4'b0001;
    nedge(1);
    aresetn = 1'b1;
    nedge(1);
    chk("t6_grant0", grant_id, 0);
    chk("t6_no_resume", tx_valid, 0);
    chk("t6_ready0", req_ready, 4'b0001);
    nedge(1);
    chk("t6_dataC0", tx_data, 8'hC0);
    chk("t6_txvC0", tx_valid, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, meaning number of requester ports (2..8).
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 1024, meaning max idle cycles of a granted requester mid-packet before grant is revoked.
REQ-003 SHALL provide port aclk  input  1  clock.
REQ-004 SHALL provide port aresetn  input  1  reset; asynchronous, active-low; clock aclk.
REQ-005 SHALL provide port req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 SHALL provide port req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 SHALL provide port req_last  input  NUM_REQ  marks final byte of a requester's packet.
REQ-008 SHALL provide port req_ready  output  NUM_REQ  per-requester byte accept.
REQ-009 SHALL provide port tx_valid  output  1  byte available to the UART transmitter.
REQ-010 SHALL provide port tx_data  output  8  byte to the UART transmitter.
REQ-011 SHALL provide port tx_ready  input  1  transmitter pop; may be a single-cycle pulse.
REQ-012 SHALL provide port grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-013 SHALL provide port busy  output  1  high in XFER or while tx_valid=1.
REQ-014 SHALL provide port timeout_pulse  output  1  one-cycle pulse on grant revocation.

Function
REQ-015 SHALL implement FSM states ARB and XFER.
REQ-016 In ARB, with any req_valid high, SHALL pick round-robin: the first valid index searched upward from (last_grant+1) mod NUM_REQ, then register grant_id and enter XFER on the next edge.
REQ-017 In ARB with no req_valid, SHALL remain in ARB with grant_id unchanged.
REQ-018 SHALL drive req_ready[i] combinationally = (state==XFER) && (grant_id==i) && (!tx_valid || tx_ready); all other bits 0.
REQ-019 A beat transfers on req_valid[g] && req_ready[g]; tx_data <= req_data[g] and tx_valid <= 1 on that edge (one-cycle latency).
REQ-020 SHALL hold tx_valid and tx_data stable until tx_ready=1 is sampled with tx_valid=1.
REQ-021 On tx_ready with tx_valid and no same-cycle beat, SHALL clear tx_valid next cycle; a same-cycle beat SHALL reload tx_valid=1 with no bubble.
REQ-022 SHALL ignore tx_ready while tx_valid=0.
REQ-023 On a transferred beat with req_last[g]=1, SHALL enter ARB next cycle and record last_grant=g; packets from different requesters SHALL never interleave.
REQ-024 In XFER, an idle counter SHALL increment each cycle req_valid[g]=0, and SHALL clear on every transferred beat and on entry to XFER.
REQ-025 When the idle counter reaches TIMEOUT_CYC-1, SHALL enter ARB, record last_grant=g, and pulse timeout_pulse for exactly one cycle; a pending tx_valid byte SHALL still be delivered.
REQ-026 The idle counter SHALL be sized $clog2(TIMEOUT_CYC)+1 bits and SHALL saturate; it SHALL never wrap.
REQ-027 When a request arrives in ARB while tx_valid is still held, SHALL arbitrate normally; req_ready SHALL remain gated by REQ-018.
REQ-028 A requester dropping req_valid mid-packet without a timeout SHALL keep its grant.

Reset
REQ-029 While aresetn=0, SHALL force: state=ARB, tx_valid=0, tx_data=8'h00, req_ready=0, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 wins first), busy=0, timeout_pulse=0, idle counter=0.
REQ-030 Reset assertion mid-packet SHALL immediately drop tx_valid; the partial byte SHALL be discarded with no resumption after release.
REQ-031 The first arbitration SHALL be possible on the first clock edge after aresetn deasserts.

Verification
REQ-032 Single requester: req1 sends 0x41,0x42(last); tx_ready pulses 1 cycle after each tx_valid -> tx_data 0x41 then 0x42, grant_id=1, ARB after last.
REQ-033 Contention: all 4 req_valid with 1-byte packets (last=1) after reset -> grant order 0,1,2,3,0.
REQ-034 Non-interleave: req0 3-byte packet AA,BB,CC while req2 is valid -> tx sees AA,BB,CC, then req2's bytes.
REQ-035 Backpressure: tx_ready held 0 for 500 cycles -> tx_data stable, req_ready=0, no timeout_pulse.
REQ-036 Timeout: TIMEOUT_CYC=16, req3 sends 1 byte (last=0) then stalls -> timeout_pulse at 16th idle cycle, req1 granted next.
REQ-037 Reset mid-packet: aresetn low during XFER with tx_valid=1 -> tx_valid=0 asynchronously; after release, req0 wins first.
